// File: rtl/kd_tree_pkg.sv
// Shared types and helpers for the KD-tree traversal pipeline.
// Build with KD_TREE_SIGNED_COMPARE_EN defined for two's-complement median compares.
package kd_tree_pkg;

  localparam int KD_DIM_WIDTH = 11;

`ifdef KD_TREE_SIGNED_COMPARE_EN
  localparam bit KD_SIGNED_CMP = 1'b1;
`else
  localparam bit KD_SIGNED_CMP = 1'b0;
`endif

  // Node word layout: median in the upper half, dimension index in the lower half.
  typedef struct packed {
    logic [KD_DIM_WIDTH-1:0] median;
    logic [KD_DIM_WIDTH-1:0] dim;
  } kd_node_t;

  function automatic int kd_num_nodes(input int depth);
    return (1 << depth) - 1;
  endfunction

  function automatic int kd_address_width(input int depth);
    return depth;
  endfunction

  // Flipping the sign bit of both operands turns an unsigned compare into a signed one.
  function automatic logic kd_less(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [31:0] flip;
    flip = KD_SIGNED_CMP ? (32'd1 << (w - 1)) : 32'd0;
    return (a ^ flip) < (b ^ flip);
  endfunction

endpackage

// File: rtl/kd_tree_level_stage.sv
// One tree level: select this level's node, compare the chosen patch component
// against its median and register the child address alongside the patch.
module kd_tree_level_stage
  import kd_tree_pkg::*;
#(
  parameter int DIM_WIDTH = KD_DIM_WIDTH,
  parameter int NUM_DIMS  = 5,
  parameter int DEPTH     = 8,
  parameter bit LAST      = 1'b0,
  localparam int NODE_WIDTH  = 2 * DIM_WIDTH,
  localparam int NUM_NODES   = kd_num_nodes(DEPTH),
  localparam int PATCH_WIDTH = NUM_DIMS * DIM_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_en,
  input  logic                                 i_vld,
  input  logic [DEPTH-1:0]                     i_addr,
  input  logic [PATCH_WIDTH-1:0]               i_patch,
  input  logic [NUM_NODES-1:0][NODE_WIDTH-1:0] i_nodes,
  output logic                                 o_vld,
  output logic [DEPTH-1:0]                     o_addr,
  output logic [PATCH_WIDTH-1:0]               o_patch
);

  // The last level emits leaf numbers instead of heap addresses.
  localparam logic [DEPTH:0] LEAF_OFS = LAST ? (DEPTH+1)'(NUM_NODES) : '0;

  logic [NODE_WIDTH-1:0] w_node;
  logic [DIM_WIDTH-1:0]  w_dim;
  logic [DIM_WIDTH-1:0]  w_med;
  logic [DIM_WIDTH-1:0]  w_comp;
  logic                  w_left;
  logic [DEPTH:0]        w_child;

  assign w_node = i_nodes[i_addr];
  assign w_dim  = w_node[DIM_WIDTH-1:0];
  assign w_med  = w_node[NODE_WIDTH-1:DIM_WIDTH];

  // Out-of-range dimension indices fall back to component 0.
  always_comb begin
    w_comp = i_patch[DIM_WIDTH-1:0];
    for (int k = 1; k < NUM_DIMS; k++) begin
      if (w_dim == DIM_WIDTH'(k)) w_comp = i_patch[k*DIM_WIDTH +: DIM_WIDTH];
    end
  end

  assign w_left  = kd_less(32'(w_comp), 32'(w_med), DIM_WIDTH);
  assign w_child = {i_addr, 1'b0} + (w_left ? (DEPTH+1)'(1) : (DEPTH+1)'(2));

  // ---- level register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      o_vld   <= 1'b0;
      o_addr  <= '0;
      o_patch <= '0;
    end else if (i_en) begin
      o_vld   <= i_vld;
      o_addr  <= DEPTH'(w_child - LEAF_OFS);
      o_patch <= i_patch;
    end
  end

endmodule

// File: rtl/kd_tree_traverse_pipe.sv
// KD-tree traversal engine: breadth-first node store loaded in beats, then one
// query per cycle routed through DEPTH level stages. Optional macro: KD_TREE_SIGNED_COMPARE_EN.
module kd_tree_traverse_pipe
  import kd_tree_pkg::*;
#(
  parameter int DIM_WIDTH   = KD_DIM_WIDTH,
  parameter int NUM_DIMS    = 5,
  parameter int DEPTH       = 8,
  parameter int FETCH_WIDTH = 2,
  localparam int NODE_WIDTH    = 2 * DIM_WIDTH,
  localparam int NUM_NODES     = kd_num_nodes(DEPTH),
  localparam int ADDRESS_WIDTH = kd_address_width(DEPTH),
  localparam int PATCH_WIDTH   = NUM_DIMS * DIM_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load_clear,
  input  logic                              load_valid,
  output logic                              load_ready,
  input  logic [FETCH_WIDTH*NODE_WIDTH-1:0] load_data,
  output logic                              tree_loaded,
  input  logic                              query_valid,
  output logic                              query_ready,
  input  logic [PATCH_WIDTH-1:0]            patch_in,
  output logic                              leaf_valid,
  input  logic                              leaf_ready,
  output logic [ADDRESS_WIDTH-1:0]          leaf_index,
  output logic [PATCH_WIDTH-1:0]            patch_out
);

  localparam int WP_W = $clog2(NUM_NODES + FETCH_WIDTH + 1);

  logic [NUM_NODES-1:0][NODE_WIDTH-1:0] r_nodes;
  logic [WP_W-1:0]                      r_wp;
  logic                                 r_loaded;
  logic                                 r_pend;

  logic                     w_vld   [DEPTH+1];
  logic [ADDRESS_WIDTH-1:0] w_addr  [DEPTH+1];
  logic [PATCH_WIDTH-1:0]   w_patch [DEPTH+1];
  logic w_busy, w_stall, w_adv, w_q_acc, w_ld_acc, w_clear_go;

  always_comb begin
    w_busy = 1'b0;
    for (int s = 1; s <= DEPTH; s++) w_busy = w_busy | w_vld[s];
  end

  assign w_stall     = w_vld[DEPTH] && !leaf_ready;
  assign w_adv       = !w_stall;
  assign query_ready = r_loaded && !r_pend && !w_stall;
  assign w_q_acc     = query_valid && query_ready;
  assign load_ready  = !r_loaded && !w_busy && !load_clear;
  assign w_ld_acc    = load_valid && load_ready;
  // A clear requested while queries are in flight waits until the pipeline drains.
  assign w_clear_go  = (load_clear || r_pend) && !w_busy;

  assign tree_loaded = r_loaded;
  assign leaf_valid  = w_vld[DEPTH];
  assign leaf_index  = w_addr[DEPTH];
  assign patch_out   = w_patch[DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp     <= '0;
      r_loaded <= 1'b0;
      r_pend   <= 1'b0;
    end else if (w_clear_go) begin
      r_wp     <= '0;
      r_loaded <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      if (load_clear) r_pend <= 1'b1;
      if (w_ld_acc) begin
        r_wp <= r_wp + WP_W'(FETCH_WIDTH);
        if (int'(r_wp) + FETCH_WIDTH >= NUM_NODES) r_loaded <= 1'b1;
      end
    end
  end

  // Slices past the last node of the final beat are dropped.
  always_ff @(posedge clk) begin
    if (w_ld_acc) begin
      for (int j = 0; j < FETCH_WIDTH; j++) begin
        if (int'(r_wp) + j < NUM_NODES)
          r_nodes[ADDRESS_WIDTH'(int'(r_wp) + j)] <= load_data[j*NODE_WIDTH +: NODE_WIDTH];
      end
    end
  end

  // ---- query entry: root address 0 ----
  assign w_vld[0]   = w_q_acc;
  assign w_addr[0]  = '0;
  assign w_patch[0] = patch_in;

  for (genvar s = 0; s < DEPTH; s++) begin : g_level
    kd_tree_level_stage #(
      .DIM_WIDTH (DIM_WIDTH),
      .NUM_DIMS  (NUM_DIMS),
      .DEPTH     (DEPTH),
      .LAST      (s == DEPTH - 1)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_adv),
      .i_vld   (w_vld[s]),
      .i_addr  (w_addr[s]),
      .i_patch (w_patch[s]),
      .i_nodes (r_nodes),
      .o_vld   (w_vld[s+1]),
      .o_addr  (w_addr[s+1]),
      .o_patch (w_patch[s+1])
    );
  end

endmodule
